spike_addr_tx: RTL and testbench

Transmit side of the per-timestep spike address bus. It captures the spike flags of a neuron group at the end of a timestep. It serialises the index of every spiking neuron as a 12-bit source address, one per accepted transfer, to downstream synapse MAC units. It then drives the `clear` timestep marker those units use to latch accumulated spikes and start the next timestep.

---
 rtl/snn_bus_pkg.sv | 11 +
 rtl/spike_prio_enc.sv | 18 +
 rtl/spike_addr_tx.sv | 134 +++++++++++++
 tb/tb_spike_addr_tx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/snn_bus_pkg.sv
// Shared types and constants for the spike address bus (transmit and receive sides).
package snn_bus_pkg;
  localparam int ADDR_W_DEF = 12;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    CLEAR = 2'd2
  } tx_state_t;
endpackage

// File: rtl/spike_prio_enc.sv
// Lowest-set-bit encoder: index of the lowest asserted bit plus an any-bit flag.
module spike_prio_enc #(
  parameter int N     = 10,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  // Scan downward so the lowest set bit is the last to be written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (vec[i]) idx = IDX_W'(i);
  end

  assign any = |vec;
endmodule

// File: rtl/spike_addr_tx.sv
// Spike address transmitter: captures a timestep's spike flags, serialises the
// source addresses lowest index first, then drives the clear marker.
// Optional spike statistics are enabled with the SPIKE_ADDR_TX_STATS_EN macro.
module spike_addr_tx
  import snn_bus_pkg::*;
#(
  parameter int                NUM_NEURONS  = 10,
  parameter int                ADDR_W       = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int                CLEAR_CYCLES = 2
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NUM_NEURONS-1:0] spike_vec,
  input  logic                   spike_vec_valid,
  output logic                   capture_ready,
  output logic [ADDR_W-1:0]      source_address,
  output logic                   addr_valid,
  input  logic                   addr_ready,
  output logic                   clear,
  output logic                   done,
  output logic                   overrun,
  output logic [CNT_W-1:0]       spike_count
);
  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int CC_W  = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  tx_state_t              state;
  logic [NUM_NEURONS-1:0] pending;
  logic [NUM_NEURONS-1:0] enc_in;
  logic [IDX_W-1:0]       cur_idx;
  logic [IDX_W-1:0]       nxt_idx;
  logic                   nxt_any;
  logic [CC_W-1:0]        clr_cnt;
  logic                   xfer;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] i);
    return BASE_ADDR + ADDR_W'(i);
  endfunction

  // In IDLE the encoder looks at the incoming vector so the first address is
  // ready at capture; in SEND it sees what remains after the current offer.
  assign enc_in = (state == IDLE) ? spike_vec
                                  : (pending & ~(NUM_NEURONS'(1) << cur_idx));
  assign xfer   = (state == SEND) && addr_valid && addr_ready;

  spike_prio_enc #(.N(NUM_NEURONS), .IDX_W(IDX_W)) u_enc (
    .vec (enc_in),
    .idx (nxt_idx),
    .any (nxt_any)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state          <= IDLE;
      pending        <= '0;
      cur_idx        <= '0;
      clr_cnt        <= '0;
      source_address <= '0;
      addr_valid     <= 1'b0;
      clear          <= 1'b0;
      done           <= 1'b0;
      overrun        <= 1'b0;
      capture_ready  <= 1'b1;
    end else begin
      done <= 1'b0;
      if (spike_vec_valid && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (spike_vec_valid) begin
          pending       <= spike_vec;
          capture_ready <= 1'b0;
          if (nxt_any) begin
            state          <= SEND;
            addr_valid     <= 1'b1;
            cur_idx        <= nxt_idx;
            source_address <= addr_of(nxt_idx);
          end else begin
            state   <= CLEAR;
            clear   <= 1'b1;
            clr_cnt <= CC_W'(CLEAR_CYCLES - 1);
          end
        end
        SEND: if (xfer) begin
          pending <= enc_in;
          if (nxt_any) begin
            cur_idx        <= nxt_idx;
            source_address <= addr_of(nxt_idx);
          end else begin
            state      <= CLEAR;
            addr_valid <= 1'b0;
            clear      <= 1'b1;
            clr_cnt    <= CC_W'(CLEAR_CYCLES - 1);
          end
        end
        CLEAR: begin
          if (clr_cnt == '0) begin
            state         <= IDLE;
            clear         <= 1'b0;
            done          <= 1'b1;
            capture_ready <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPIKE_ADDR_TX_STATS_EN
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             to_clear;

  // cnt_inc already includes the final transfer, which lands on the same edge
  // as entry to CLEAR.
  assign cnt_inc  = (xfer && cnt != '1) ? cnt + 1'b1 : cnt;
  assign to_clear = ((state == IDLE) && spike_vec_valid && !nxt_any) || (xfer && !nxt_any);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt         <= '0;
      spike_count <= '0;
    end else if (to_clear) begin
      spike_count <= cnt_inc;
      cnt         <= '0;
    end else begin
      cnt <= cnt_inc;
    end
  end
`else
  assign spike_count = '0;
`endif
endmodule

// File: tb/tb_spike_addr_tx.sv
// Self-checking bench for spike_addr_tx: directed and randomized timesteps checked
// against an index-queue reference model, on two instances with different base addresses.
module tb_spike_addr_tx;
  localparam int          N      = 10;
  localparam int          CC     = 2;
  localparam logic [11:0] BASE_B = 12'hFFC;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [N-1:0]  spike_vec = '0;
  logic          spike_vec_valid = 1'b0;
  logic          addr_ready = 1'b0;

  logic          capture_ready_a, addr_valid_a, clear_a, done_a, overrun_a;
  logic [11:0]   source_address_a;
  logic [15:0]   spike_count_a;
  logic          capture_ready_b, addr_valid_b, clear_b, done_b, overrun_b;
  logic [11:0]   source_address_b;
  logic [15:0]   spike_count_b;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  spike_addr_tx #(.NUM_NEURONS(N), .ADDR_W(12), .BASE_ADDR(12'h000), .CLEAR_CYCLES(CC)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .spike_vec(spike_vec), .spike_vec_valid(spike_vec_valid),
    .capture_ready(capture_ready_a), .source_address(source_address_a), .addr_valid(addr_valid_a),
    .addr_ready(addr_ready), .clear(clear_a), .done(done_a), .overrun(overrun_a),
    .spike_count(spike_count_a));

  spike_addr_tx #(.NUM_NEURONS(N), .ADDR_W(12), .BASE_ADDR(BASE_B), .CLEAR_CYCLES(CC)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .spike_vec(spike_vec), .spike_vec_valid(spike_vec_valid),
    .capture_ready(capture_ready_b), .source_address(source_address_b), .addr_valid(addr_valid_b),
    .addr_ready(addr_ready), .clear(clear_b), .done(done_b), .overrun(overrun_b),
    .spike_count(spike_count_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One timestep: the model is the ascending list of set indices; each accepted
  // transfer pops one, then CC clear cycles, then a single done cycle.
  task automatic run_ts(input logic [N-1:0] vec, input int stall, input bit rnd,
                        input bit mid_strobe, input bit late_strobe);
    int q[$];
    int guard;
    int exp_cnt;
    for (int i = 0; i < N; i++) if (vec[i]) q.push_back(i);
    exp_cnt = q.size();
    chk("cready_before", capture_ready_a, 1);
    spike_vec       = vec;
    spike_vec_valid = 1'b1;
    step();
    spike_vec_valid = 1'b0;
    spike_vec       = N'($urandom);
    guard = 0;
    while (q.size() > 0 && guard < 200) begin
      guard++;
      chk("valid_a", addr_valid_a, 1);
      chk("valid_b", addr_valid_b, 1);
      chk("addr_a", source_address_a, 12'(q[0]));
      chk("addr_b", source_address_b, 12'(BASE_B + 12'(q[0])));
      chk("clear_in_send", clear_a, 0);
      chk("cready_in_send", capture_ready_a, 0);
      if (stall > 0) begin
        addr_ready = 1'b0;
        stall--;
      end else begin
        addr_ready = rnd ? 1'($urandom % 2) : 1'b1;
      end
      if (mid_strobe && guard == 1) begin
        spike_vec_valid = 1'b1;
        spike_vec       = '1;
      end else begin
        spike_vec_valid = 1'b0;
      end
      if (addr_ready) void'(q.pop_front());
      step();
    end
    spike_vec_valid = 1'b0;
    addr_ready      = 1'b0;
    chk("send_drained", q.size(), 0);
    for (int c = 0; c < CC; c++) begin
      chk("clear_a_on", clear_a, 1);
      chk("clear_b_on", clear_b, 1);
      chk("valid_in_clear", addr_valid_a, 0);
      chk("done_early", done_a, 0);
      if (late_strobe && c == CC - 1) begin
        spike_vec_valid = 1'b1;
        spike_vec       = vec | N'(1);
      end
      step();
      spike_vec_valid = 1'b0;
    end
    chk("clear_off", clear_a, 0);
    chk("done_a", done_a, 1);
    chk("done_b", done_b, 1);
    chk("cready_a", capture_ready_a, 1);
    chk("cready_b", capture_ready_b, 1);
    chk("valid_after", addr_valid_a, 0);
`ifdef SPIKE_ADDR_TX_STATS_EN
    chk("count_a", spike_count_a, exp_cnt);
    chk("count_b", spike_count_b, exp_cnt);
`else
    chk("count_a", spike_count_a, 0);
    chk("count_b", spike_count_b, 0);
    exp_cnt = 0;
`endif
    step();
    chk("done_pulse", done_a, 0);
    chk("clear_idle", clear_a, 0);
    chk("valid_idle", addr_valid_a, 0);
  endtask

  initial begin
    #12;
    chk("rst_cready", capture_ready_a, 1);
    chk("rst_valid", addr_valid_a, 0);
    chk("rst_addr", source_address_a, 0);
    chk("rst_clear", clear_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_overrun", overrun_a, 0);
    chk("rst_count", spike_count_a, 0);
    step();
    RST_N = 1'b1;
    step();

    run_ts(10'b00_0000_0101, 0, 1'b0, 1'b0, 1'b0);
    run_ts(10'b00_0000_0101, 3, 1'b0, 1'b0, 1'b0);
    run_ts(10'b0, 0, 1'b0, 1'b0, 1'b0);
    run_ts(10'h3FF, 0, 1'b0, 1'b0, 1'b0);
    run_ts(10'h3FF, 0, 1'b1, 1'b0, 1'b0);
    for (int t = 0; t < 8; t++) run_ts(N'($urandom), 0, 1'b1, 1'b0, 1'b0);
    chk("overrun_clean", overrun_a, 0);

    run_ts(10'b00_0101_0010, 0, 1'b0, 1'b1, 1'b0);
    chk("overrun_mid", overrun_a, 1);
    chk("overrun_mid_b", overrun_b, 1);
    run_ts(10'b00_0000_0011, 0, 1'b0, 1'b0, 1'b1);
    chk("overrun_sticky", overrun_a, 1);

    // Reset part-way through a three-spike timestep.
    spike_vec       = 10'b01_0010_0001;
    spike_vec_valid = 1'b1;
    step();
    spike_vec_valid = 1'b0;
    addr_ready      = 1'b1;
    chk("rs_first", source_address_a, 0);
    step();
    chk("rs_second", source_address_a, 5);
    chk("rs_valid", addr_valid_a, 1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("rs_valid0", addr_valid_a, 0);
    chk("rs_addr0", source_address_a, 0);
    chk("rs_clear0", clear_a, 0);
    chk("rs_cready1", capture_ready_a, 1);
    chk("rs_overrun0", overrun_a, 0);
    chk("rs_count0", spike_count_a, 0);
    step();
    step();
    chk("rs_no_clear", clear_a, 0);
    chk("rs_no_done", done_a, 0);
    RST_N      = 1'b1;
    addr_ready = 1'b0;
    step();
    run_ts(10'b10_0000_0001, 0, 1'b1, 1'b0, 1'b0);
    chk("rs_overrun_after", overrun_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
